instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 8051 core. It owns the program counter and steps each instruction through fetch, operand fetch, RAM operand reads, execute and write-back. It drives the ROM port and the RAM read/write strobes, and emits a one-cycle execute strobe that the datapath uses to latch ALU and PSW results. The opcode decoder is combinational on `ir` and reports instruction length and RAM access needs back to this block.

---
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle 8051 instruction sequencer: owns the PC and steps fetch, operands, RAM reads,
// execute and write-back. Define SEQ_RAM_ACK_EN to hold RAM phases until ram_ack.
module instr_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   output logic [15:0] rom_addr,
   output logic        rom_rd,
   input  logic [7:0]  rom_data,
   input  logic [1:0]  ilen,
   input  logic [1:0]  need_rd,
   input  logic        need_wr,
   input  logic        branch_en,
   input  logic [15:0] branch_target,
   input  logic        ram_ack,
   output logic        ram_rd,
   output logic        ram_wr,
   output logic [1:0]  ram_phase,
   output logic [7:0]  ir,
   output logic [7:0]  op1,
   output logic [7:0]  op2,
   output logic [15:0] pc,
   output logic        exec_en,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StLatch  = 4'd1,
      StDecode = 4'd2,
      StOpnd1  = 4'd3,
      StOpnd2  = 4'd4,
      StRd1    = 4'd5,
      StRd2    = 4'd6,
      StExec   = 4'd7,
      StWb     = 4'd8
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  ir_q, op1_q, op2_q;
   logic [1:0]  ilen_q, nrd_q;
   logic        nwr_q;
   logic [1:0]  ilen_eff, nrd_eff;
   logic        ram_done;

   assign ilen_eff = (ilen == 2'd0) ? 2'd1 : ilen;
   assign nrd_eff  = (need_rd == 2'd3) ? 2'd2 : need_rd;

`ifdef SEQ_RAM_ACK_EN
   assign ram_done = ram_ack;
`else
   // RAM always completes in one cycle; ram_ack is folded in only to keep it referenced.
   assign ram_done = 1'b1 | ram_ack;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:  if (!stall) state_d = StLatch;
         StLatch:  state_d = StDecode;
         StDecode: begin
            if (ilen_eff >= 2'd2)      state_d = StOpnd1;
            else if (nrd_eff != 2'd0)  state_d = StRd1;
            else                       state_d = StExec;
         end
         StOpnd1: begin
            if (ilen_q == 2'd3)        state_d = StOpnd2;
            else if (nrd_q != 2'd0)    state_d = StRd1;
            else                       state_d = StExec;
         end
         StOpnd2:  state_d = (nrd_q != 2'd0) ? StRd1 : StExec;
         StRd1:    if (ram_done) state_d = (nrd_q == 2'd2) ? StRd2 : StExec;
         StRd2:    if (ram_done) state_d = StExec;
         StExec:   state_d = nwr_q ? StWb : StFetch;
         StWb:     if (ram_done) state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   always_comb begin
      // Gated by reset so every strobe reads 0 while reset is held.
      rom_rd    = reset && (((state_q == StFetch) && !stall) ||
                            ((state_q == StDecode) && (ilen_eff >= 2'd2)) ||
                            ((state_q == StOpnd1) && (ilen_q == 2'd3)));
      rom_addr  = pc_q;
      ram_rd    = (state_q == StRd1) || (state_q == StRd2);
      ram_wr    = (state_q == StWb);
      exec_en   = (state_q == StExec);
      ram_phase = 2'd0;
      if (state_q == StRd2) ram_phase = 2'd1;
      if (state_q == StWb)  ram_phase = 2'd2;
      pc_d = pc_q;
      if (rom_rd)                                pc_d = pc_q + 16'd1;
      else if ((state_q == StExec) && branch_en) pc_d = branch_target;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q   <= 16'd0;
         ir_q   <= 8'd0;
         op1_q  <= 8'd0;
         op2_q  <= 8'd0;
         ilen_q <= 2'd1;
         nrd_q  <= 2'd0;
         nwr_q  <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (state_q == StLatch) ir_q  <= rom_data;
         if (state_q == StOpnd1) op1_q <= rom_data;
         if (state_q == StOpnd2) op2_q <= rom_data;
         if (state_q == StDecode) begin
            ilen_q <= ilen_eff;
            nrd_q  <= nrd_eff;
            nwr_q  <= need_wr;
         end
      end
   end

   assign pc    = pc_q;
   assign ir    = ir_q;
   assign op1   = op1_q;
   assign op2   = op2_q;
   assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: synchronous ROM model and an opcode decoder table
// driving ilen/need_rd/need_wr/branch_en from ir.
module tb_instr_sequencer;

   localparam logic [3:0] S_FETCH = 4'd0, S_LATCH = 4'd1, S_DECODE = 4'd2, S_OPND1 = 4'd3,
                          S_OPND2 = 4'd4, S_RD1 = 4'd5, S_RD2 = 4'd6, S_EXEC = 4'd7,
                          S_WB = 4'd8;

   logic        clock, reset, stall;
   logic [15:0] rom_addr;
   logic        rom_rd;
   logic [7:0]  rom_data;
   logic [1:0]  ilen, need_rd;
   logic        need_wr, branch_en;
   logic [15:0] branch_target;
   logic        ram_ack, ram_rd, ram_wr;
   logic [1:0]  ram_phase;
   logic [7:0]  ir, op1, op2;
   logic [15:0] pc;
   logic        exec_en;
   logic [3:0]  state;

   logic [7:0]  mem [0:65535];
   int          n_checks = 0;
   int          n_fail = 0;

   instr_sequencer dut (
      .clock(clock), .reset(reset), .stall(stall), .rom_addr(rom_addr), .rom_rd(rom_rd),
      .rom_data(rom_data), .ilen(ilen), .need_rd(need_rd), .need_wr(need_wr),
      .branch_en(branch_en), .branch_target(branch_target), .ram_ack(ram_ack),
      .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_phase(ram_phase), .ir(ir), .op1(op1),
      .op2(op2), .pc(pc), .exec_en(exec_en), .state(state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) if (rom_rd) rom_data <= mem[rom_addr];

   // Opcode table: 25h = 3 bytes/2 reads/write, 74h = 2 bytes/1 read, 80h = branch,
   // A0h = out-of-range ilen 0 / need_rd 3, anything else = 1-byte NOP.
   always_comb begin
      ilen = 2'd1; need_rd = 2'd0; need_wr = 1'b0; branch_en = 1'b0;
      case (ir)
         8'h25: begin ilen = 2'd3; need_rd = 2'd2; need_wr = 1'b1; end
         8'h74: begin ilen = 2'd2; need_rd = 2'd1; end
         8'h80: branch_en = 1'b1;
         8'hA0: begin ilen = 2'd0; need_rd = 2'd3; end
         default: ;
      endcase
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish before 100000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " pc"}, 32'(pc), 0);
      check({tag, " ir"}, 32'(ir), 0);
      check({tag, " op1"}, 32'(op1), 0);
      check({tag, " op2"}, 32'(op2), 0);
      check({tag, " rom_rd"}, 32'(rom_rd), 0);
      check({tag, " ram_rd"}, 32'(ram_rd), 0);
      check({tag, " ram_wr"}, 32'(ram_wr), 0);
      check({tag, " exec_en"}, 32'(exec_en), 0);
      check({tag, " ram_phase"}, 32'(ram_phase), 0);
      check({tag, " state"}, 32'(state), 32'(S_FETCH));
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'h00;
      mem[16'h0001] = 8'h25; mem[16'h0002] = 8'h30; mem[16'h0003] = 8'h40;
      mem[16'h0004] = 8'h80;
      mem[16'h1234] = 8'hA0;
      mem[16'h1235] = 8'h80;
      mem[16'hFFFF] = 8'h74;
      reset = 1'b0; stall = 1'b0; ram_ack = 1'b1; branch_target = 16'h1234;

      step(); step();
      check_reset_values("reset");

      // NOP at 0
      reset = 1'b1; #1;
      check("nop fetch rom_rd", 32'(rom_rd), 1);
      check("nop fetch rom_addr", 32'(rom_addr), 0);
      step(); check("nop latch state", 32'(state), 32'(S_LATCH));
      check("nop latch pc", 32'(pc), 1);
      step(); check("nop decode state", 32'(state), 32'(S_DECODE));
      step(); check("nop exec_en c4", 32'(exec_en), 1);
      step(); check("nop next fetch state", 32'(state), 32'(S_FETCH));
      check("nop next pc", 32'(pc), 1);
      check("nop exec_en low", 32'(exec_en), 0);

      // 3-byte, 2 reads, write at 1
      check("i3 fetch addr", 32'(rom_addr), 1);
      step(); check("i3 latch", 32'(state), 32'(S_LATCH));
      step(); check("i3 ir", 32'(ir), 32'h25);
      check("i3 decode rom_rd", 32'(rom_rd), 1);
      check("i3 decode addr", 32'(rom_addr), 2);
      step(); check("i3 opnd1", 32'(state), 32'(S_OPND1));
      check("i3 opnd1 addr", 32'(rom_addr), 3);
      check("i3 opnd1 rom_rd", 32'(rom_rd), 1);
      step(); check("i3 op1", 32'(op1), 32'h30);
      check("i3 opnd2", 32'(state), 32'(S_OPND2));
      step(); check("i3 op2", 32'(op2), 32'h40);
      check("i3 rd1 ram_rd", 32'(ram_rd), 1);
      check("i3 rd1 phase", 32'(ram_phase), 0);
      step(); check("i3 rd2 state", 32'(state), 32'(S_RD2));
      check("i3 rd2 phase", 32'(ram_phase), 1);
      step(); check("i3 exec_en", 32'(exec_en), 1);
      step(); check("i3 wb ram_wr", 32'(ram_wr), 1);
      check("i3 wb phase", 32'(ram_phase), 2);
      step(); check("i3 9 cycles fetch", 32'(state), 32'(S_FETCH));
      check("i3 pc", 32'(pc), 4);

      // stall 5 cycles at pc 4
      stall = 1'b1; #1;
      check("stall rom_rd", 32'(rom_rd), 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall state", 32'(state), 32'(S_FETCH));
         check("stall pc", 32'(pc), 4);
      end
      stall = 1'b0; #1;
      check("unstall rom_rd", 32'(rom_rd), 1);

      // branch at 4 to 1234; stall during LATCH must be ignored
      step(); stall = 1'b1;
      step(); check("stall ignored", 32'(state), 32'(S_DECODE));
      stall = 1'b0;
      step(); check("br exec_en", 32'(exec_en), 1);
      step(); check("br fetch", 32'(state), 32'(S_FETCH));
      check("br rom_addr", 32'(rom_addr), 32'h1234);
      branch_target = 16'hFFFF;

      // A0: ilen 0 -> 1 byte, need_rd 3 -> 2 reads
      step(); step();
      check("a0 decode no rom_rd", 32'(rom_rd), 0);
`ifdef SEQ_RAM_ACK_EN
      ram_ack = 1'b0;
      step(); check("ack rd1 c1", 32'(ram_rd), 1);
      step(); check("ack rd1 c2", 32'(state), 32'(S_RD1));
      step(); check("ack rd1 c3", 32'(state), 32'(S_RD1));
      ram_ack = 1'b1;
`else
      step(); check("a0 rd1", 32'(state), 32'(S_RD1));
`endif
      step(); check("a0 rd2", 32'(state), 32'(S_RD2));
      step(); check("a0 exec", 32'(exec_en), 1);
      check("a0 op1 kept", 32'(op1), 32'h30);
      check("a0 op2 kept", 32'(op2), 32'h40);
      step(); check("a0 next pc", 32'(pc), 32'h1235);

      // branch at 1235 to FFFF
      step(); step(); step();
      step(); check("br2 pc", 32'(pc), 32'hFFFF);

      // 2-byte at FFFF wraps
      check("wrap opcode addr", 32'(rom_addr), 32'hFFFF);
      step(); check("wrap pc after opcode", 32'(pc), 0);
      step(); check("wrap operand addr", 32'(rom_addr), 0);
      check("wrap operand rom_rd", 32'(rom_rd), 1);
      step(); check("wrap pc", 32'(pc), 1);
      check("wrap opnd1 no rom_rd", 32'(rom_rd), 0);
      step(); check("wrap rd1", 32'(state), 32'(S_RD1));
      step(); check("wrap exec", 32'(exec_en), 1);
      check("wrap op1", 32'(op1), 0);
      step(); check("wrap fetch", 32'(state), 32'(S_FETCH));

      // 25h at 1, reset in RD2
      step(); step(); step(); step(); step(); step();
      check("pre-reset rd2", 32'(state), 32'(S_RD2));
      reset = 1'b0; #1;
      check_reset_values("midreset");
      step(); reset = 1'b1; #1;
      check("restart addr", 32'(rom_addr), 0);
      check("restart rom_rd", 32'(rom_rd), 1);
      step(); check("restart pc", 32'(pc), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
